// File: rtl/eq_pkg.sv
// Shared types and constants for the
// equalizer pot scanner.
package eq_pkg;

  typedef enum logic [1:0] {
    GAP,
    REQ,
    BUSY
  } pot_state_t;

  localparam int NUM_POTS = 6;

  // ADC channel per slot: LP,B1,B2,B3,HP,VOL
  localparam logic [2:0] POT_CH [0:5] = '{
    3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7
  };

  function automatic logic [2:0] next_slot(
    input logic [2:0] s
  );
    if (s == 3'(NUM_POTS - 1))
      return 3'd0;
    return s + 3'd1;
  endfunction

  function automatic logic [2:0] slot_ch(
    input logic [2:0] s
  );
    logic [2:0] ch;
    ch = POT_CH[0];
    for (int i = 0; i < NUM_POTS; i++)
      if (s == 3'(i))
        ch = POT_CH[i];
    return ch;
  endfunction

endpackage

// File: rtl/pot_scan_seq.sv
// Round-robin A2D scheduler for the six
// slide pots, with stall detection.
module pot_scan_seq
  import eq_pkg::*;
#(
  parameter int GAP_CYC = 1024,
  parameter int TMO_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic [11:0] POT_LP,
  output logic [11:0] POT_B1,
  output logic [11:0] POT_B2,
  output logic [11:0] POT_B3,
  output logic [11:0] POT_HP,
  output logic [11:0] VOLUME,
  output logic        all_vld,
  output logic        a2d_err
);

  localparam int GW =
    (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int TW = $clog2(TMO_CYC);

  localparam logic [GW-1:0] GAP_LAST =
    GW'(GAP_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TMO_CYC - 1);

  pot_state_t          state;
  logic [2:0]          slot;
  logic [GW-1:0]       gap_cnt;
  logic [TW-1:0]       tmo_cnt;
  logic [11:0]         pot [NUM_POTS];
  logic [NUM_POTS-1:0] wr_mask;
  logic                done;
  logic                tmo;

  // completion beats the timeout terminal count
  assign done = (state == BUSY) && cnv_cmplt;
  assign tmo  = (state == BUSY) && !cnv_cmplt
             && (tmo_cnt == TMO_LAST);

  assign chnnl   = slot_ch(slot);
  assign all_vld = &wr_mask;

  assign POT_LP = pot[0];
  assign POT_B1 = pot[1];
  assign POT_B2 = pot[2];
  assign POT_B3 = pot[3];
  assign POT_HP = pot[4];
  assign VOLUME = pot[5];

  // sequencer: gap wait, one request, busy wait
  // tmo_cnt counts cycles since strt_cnv, so the
  // REQ cycle itself is counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= GAP;
      slot     <= '0;
      gap_cnt  <= '0;
      tmo_cnt  <= '0;
      strt_cnv <= 1'b0;
    end else begin
      strt_cnv <= 1'b0;
      unique case (state)
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt  <= '0;
            tmo_cnt  <= '0;
            strt_cnv <= 1'b1;
            state    <= REQ;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        REQ: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          state   <= BUSY;
        end
        BUSY: begin
          if (done || tmo) begin
            slot  <= next_slot(slot);
            state <= GAP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= GAP;
      endcase
    end
  end

  // pot bank: capture result into current slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_POTS; i++)
        pot[i] <= '0;
    end else if (done) begin
      for (int i = 0; i < NUM_POTS; i++)
        if (slot == 3'(i))
          pot[i] <= res;
    end
  end

  // written bits and sticky stall flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_mask <= '0;
      a2d_err <= 1'b0;
    end else begin
      if (done) begin
        for (int i = 0; i < NUM_POTS; i++)
          if (slot == 3'(i))
            wr_mask[i] <= 1'b1;
      end
      if (tmo)
        a2d_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pot_scan_seq.sv
// Scoreboard bench for pot_scan_seq with a
// behavioural A2D model.
module tb_pot_scan_seq;

  localparam int GAP = 32;
  localparam int TMO = 128;

  // board wiring: LP,B1,B2,B3,HP,VOL
  localparam logic [2:0] ORDER_CH [6] = '{
    3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7
  };

  typedef struct {
    int          slot;
    logic [11:0] val;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] res = 12'h000;
  logic [11:0] POT_LP, POT_B1, POT_B2;
  logic [11:0] POT_B3, POT_HP, VOLUME;
  logic        all_vld;
  logic        a2d_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_strt = 0;
  int req_k = 0;

  sb_t sb_q [$];
  int  tmo_q [$];

  logic [11:0] ref_pot [6];
  bit   [5:0]  ref_wr;
  bit          ref_err;
  bit          prev_strt;

  bit          m_busy = 0;
  bit          m_stale = 0;
  bit          m_mute = 0;
  int          m_left = 0;
  int          m_idle = 0;
  logic [2:0]  m_ch = '0;
  logic [11:0] m_val = '0;
  int          last_cmplt = 0;
  bit          cmplt_vld = 0;

  bit          cfg_rand = 0;
  int          cfg_lat = 40;
  logic [11:0] cfg_vals [8];
  int          cfg_mute = -1;
  int          cfg_term = -1;
  bit          cfg_inj = 0;

  pot_scan_seq #(
    .GAP_CYC(GAP),
    .TMO_CYC(TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .strt_cnv (strt_cnv),
    .chnnl    (chnnl),
    .cnv_cmplt(cnv_cmplt),
    .res      (res),
    .POT_LP   (POT_LP),
    .POT_B1   (POT_B1),
    .POT_B2   (POT_B2),
    .POT_B3   (POT_B3),
    .POT_HP   (POT_HP),
    .VOLUME   (VOLUME),
    .all_vld  (all_vld),
    .a2d_err  (a2d_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic void check(
    input string       name,
    input logic [71:0] act,
    input logic [71:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h cyc %0d",
               name, act, exp, cyc);
    end
  endfunction

  function automatic int slot_of(
    input logic [2:0] ch
  );
    for (int i = 0; i < 6; i++)
      if (ORDER_CH[i] == ch)
        return i;
    return -1;
  endfunction

  function automatic logic [71:0] dut_bank();
    return {POT_LP, POT_B1, POT_B2,
            POT_B3, POT_HP, VOLUME};
  endfunction

  function automatic logic [71:0] ref_bank();
    return {ref_pot[0], ref_pot[1], ref_pot[2],
            ref_pot[3], ref_pot[4], ref_pot[5]};
  endfunction

  // A2D model: answers each request after a
  // programmable latency L (sampled L edges
  // after the edge that raised strt_cnv)
  always @(negedge clk) begin
    bit was_busy;
    int lat;
    was_busy = m_busy;
    cnv_cmplt = 1'b0;
    if (!rst_n) begin
      if (m_busy) m_stale = 1'b1;
      cmplt_vld = 1'b0;
      m_idle = 0;
    end
    if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        if (!m_mute) begin
          cnv_cmplt = 1'b1;
          res = m_val;
          if (m_stale) begin
            sb_q.push_back('{-1, m_val});
          end else begin
            sb_q.push_back('{slot_of(m_ch), m_val});
            check("chnnl_stable", 72'(chnnl),
                  72'(m_ch));
            last_cmplt = cyc;
            cmplt_vld = 1'b1;
          end
        end else begin
          cmplt_vld = 1'b0;
        end
        m_stale = 1'b0;
      end
    end
    if (rst_n && strt_cnv) begin
      check("strt_while_busy", 72'(was_busy), 72'(0));
      m_busy = 1'b1;
      m_ch = chnnl;
      m_mute = (int'(chnnl) == cfg_mute);
      m_idle = 0;
      if (int'(chnnl) == cfg_term) begin
        lat = TMO;
        m_val = 12'h5A5;
      end else begin
        lat = cfg_rand ? $urandom_range(2, 60)
                       : cfg_lat;
        m_val = cfg_rand ? 12'($urandom)
                         : cfg_vals[chnnl];
      end
      if (m_mute) begin
        m_left = TMO - 1;
        tmo_q.push_back(cyc + TMO);
      end else begin
        m_left = lat - 1;
      end
    end else if (rst_n && !was_busy && !m_busy
                 && cfg_inj) begin
      m_idle++;
      if (m_idle == 5) begin
        cnv_cmplt = 1'b1;
        res = 12'hBAD;
        sb_q.push_back('{-1, 12'hBAD});
      end
    end
  end

  // monitor: pops the scoreboard on each
  // completion and checks every output cycle
  always @(posedge clk) begin
    sb_t e;
    #1;
    if (cnv_cmplt) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underflow: got cmplt expected none cyc %0d",
                 cyc);
      end else begin
        e = sb_q.pop_front();
        if (rst_n && e.slot >= 0) begin
          ref_pot[e.slot] = e.val;
          ref_wr[e.slot] = 1'b1;
        end
      end
    end
    if (!rst_n) begin
      for (int i = 0; i < 6; i++)
        ref_pot[i] = '0;
      ref_wr = '0;
      ref_err = 1'b0;
      req_k = 0;
      prev_strt = 1'b0;
      tmo_q.delete();
    end else begin
      if (tmo_q.size() != 0 && cyc == tmo_q[0]) begin
        void'(tmo_q.pop_front());
        ref_err = 1'b1;
      end
      check("pot_bank", dut_bank(), ref_bank());
      check("all_vld", 72'(all_vld), 72'(&ref_wr));
      check("a2d_err", 72'(a2d_err), 72'(ref_err));
      if (strt_cnv) begin
        check("chnnl_seq", 72'(chnnl),
              72'(ORDER_CH[req_k % 6]));
        check("strt_one_cycle", 72'(prev_strt),
              72'(0));
        if (cmplt_vld)
          check("gap_spacing", 72'(cyc - last_cmplt),
                72'(GAP + 1));
        req_k++;
        n_strt++;
      end
      prev_strt = strt_cnv;
    end
  end

  task automatic chk_reset_vals(input string tag);
    check({tag, "_rst_bank"}, dut_bank(), 72'(0));
    check({tag, "_rst_chnnl"}, 72'(chnnl), 72'(1));
    check({tag, "_rst_flags"},
          72'({strt_cnv, all_vld, a2d_err}), 72'(0));
  endtask

  task automatic wait_reqs(input int n);
    int target;
    int budget;
    target = n_strt + n;
    budget = 20000;
    while (n_strt < target && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check("req_timeout", 72'(n_strt), 72'(target));
  endtask

  task automatic wait_idle();
    int budget;
    budget = 2000;
    while (m_busy && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check("idle_timeout", 72'(m_busy), 72'(0));
    repeat (3) @(posedge clk);
  endtask

  task automatic do_reset(input string tag);
    int budget;
    wait_idle();
    budget = 2000;
    do begin
      @(posedge clk);
      #3;
      budget--;
    end while ((m_busy || strt_cnv) && budget > 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    int rel_cyc;
    for (int i = 0; i < 8; i++)
      cfg_vals[i] = 12'h800;
    cfg_vals[7] = 12'hFFF;
    repeat (3) @(negedge clk);
    chk_reset_vals("init");

    // nominal scan, fixed values
    rst_n = 1'b1;
    wait_reqs(14);
    wait_idle();
    check("a_vol", 72'(VOLUME), 72'(12'hFFF));
    check("a_lp", 72'(POT_LP), 72'(12'h800));
    check("a_all_vld", 72'(all_vld), 72'(1));
    check("a_err", 72'(a2d_err), 72'(0));

    // B2 (ch 4) never answers
    do_reset("b");
    cfg_rand = 1'b1;
    cfg_mute = 4;
    @(negedge clk);
    rst_n = 1'b1;
    wait_reqs(8);
    wait_idle();
    check("b_b2", 72'(POT_B2), 72'(0));
    check("b_all_vld", 72'(all_vld), 72'(0));
    check("b_err", 72'(a2d_err), 72'(1));

    // completion on terminal cycle, GAP noise
    do_reset("c");
    cfg_mute = -1;
    cfg_term = 4;
    cfg_inj = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_reqs(8);
    wait_idle();
    check("c_b2", 72'(POT_B2), 72'(12'h5A5));
    check("c_err", 72'(a2d_err), 72'(0));
    check("c_all_vld", 72'(all_vld), 72'(1));

    // reset during B3 conversion
    cfg_inj = 1'b0;
    cfg_term = -1;
    cfg_rand = 1'b0;
    cfg_lat = 40;
    budget = 4000;
    do begin
      @(posedge clk);
      #2;
      budget--;
    end while (!(strt_cnv && chnnl == 3'd2)
               && budget > 0);
    check("d_find_b3", 72'(budget > 0), 72'(1));
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("d");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rel_cyc = cyc;
    budget = 200;
    do begin
      @(posedge clk);
      #2;
      budget--;
    end while (!strt_cnv && budget > 0);
    // first request lands in clock cycle GAP+1
    check("d_first_req", 72'(cyc - rel_cyc), 72'(GAP));
    check("d_first_ch", 72'(chnnl), 72'(1));
    check("d_bank_clear", dut_bank(), 72'(0));
    wait_reqs(3);
    wait_idle();
    check("sb_empty", 72'(sb_q.size()), 72'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
